// File: rtl/rr_mux_reg.sv
// Registered N-to-1 multiplexer with valid/ready on every channel and on the output.
// It uses either a fixed channel select or round-robin arbitration that resumes after the last winner.
module rr_mux_reg #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_chan,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [SELW-1:0]  ptr;
  logic             armed;
  logic [NCH-1:0]   grant;
  logic             has_grant;
  logic [SELW-1:0]  win_idx;
  logic [WIDTH-1:0] win_data;
  logic [SELW-1:0]  ptr_next;
  logic             space;
  logic             load;

  assign space = !out_valid || out_ready;

  always_comb begin : grant_logic
    int pos;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = '0;
    pos   = 0;
    if (!mode) begin
      for (int i = 0; i < NCH; i++) begin
        if (int'(sel) == i && in_valid[i]) grant[i] = 1'b1;
      end
    end else begin
      // Scan from the farthest position to the nearest so the nearest valid channel after ptr wins.
      for (int k = NCH - 1; k >= 0; k--) begin
        pos = int'(ptr) + k;
        if (pos >= NCH) pos = pos - NCH;
        for (int i = 0; i < NCH; i++) begin
          if (pos == i && in_valid[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin : winner_encode
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        win_idx  = SELW'(i);
        win_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign has_grant = |grant;
  assign ptr_next  = (int'(win_idx) == NCH - 1) ? '0 : win_idx + SELW'(1);

  // armed stays low until the first edge after reset release, which keeps in_ready quiet on that edge.
  assign load     = armed && space;
  assign in_ready = armed ? (grant & {NCH{space}}) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed     <= 1'b0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      armed <= 1'b1;
      if (load) begin
        if (has_grant) begin
          out_data  <= win_data;
          out_chan  <= win_idx;
          out_valid <= 1'b1;
          if (mode) ptr <= ptr_next;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: a 4-channel and a 3-channel instance run side by side.
// A transaction-level model predicts in_ready before each edge and the output register after it.
module tb_rr_mux_reg;
  localparam int W  = 32;
  localparam int DW = 16 * W;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [4*W-1:0] a_data;
  logic [3:0]     a_valid, a_ready;
  logic           a_mode, a_out_valid, a_out_ready;
  logic [1:0]     a_sel, a_out_chan;
  logic [W-1:0]   a_out_data;

  logic [3*W-1:0] b_data;
  logic [2:0]     b_valid, b_ready;
  logic           b_mode, b_out_valid, b_out_ready;
  logic [1:0]     b_sel, b_out_chan;
  logic [W-1:0]   b_out_data;

  int n_cmp = 0;
  int n_bad = 0;

  rr_mux_reg #(.WIDTH(W), .NCH(4), .SELW(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .mode(a_mode), .sel(a_sel), .out_data(a_out_data), .out_chan(a_out_chan),
    .out_valid(a_out_valid), .out_ready(a_out_ready));

  rr_mux_reg #(.WIDTH(W), .NCH(3), .SELW(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .mode(b_mode), .sel(b_sel), .out_data(b_out_data), .out_chan(b_out_chan),
    .out_valid(b_out_valid), .out_ready(b_out_ready));

  typedef struct {
    bit           valid;
    logic [W-1:0] data;
    int           chan;
    int           ptr;
    bit           armed;
  } model_t;

  model_t ma, mb;

  // Winner by rule: fixed select, or first valid channel at or after ptr going round the ring.
  function automatic int pick(int nch, bit mode, int sel, logic [15:0] valid, int ptr);
    if (!mode) return (sel < nch && valid[sel]) ? sel : -1;
    for (int k = 0; k < nch; k++) begin
      if (valid[(ptr + k) % nch]) return (ptr + k) % nch;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_ready(model_t m, int nch, bit mode, int sel,
                                            logic [15:0] valid, bit ordy);
    int w;
    if (!m.armed) return 16'd0;
    w = pick(nch, mode, sel, valid, m.ptr);
    if (w >= 0 && (!m.valid || ordy)) return 16'd1 << w;
    return 16'd0;
  endfunction

  function automatic model_t model_edge(model_t m, int nch, bit mode, int sel,
                                        logic [15:0] valid, logic [DW-1:0] data, bit ordy);
    model_t n;
    int w;
    n = m;
    if (!m.armed) begin
      n.armed = 1'b1;
      return n;
    end
    if (m.valid && !ordy) return n;
    w = pick(nch, mode, sel, valid, m.ptr);
    if (w < 0) begin
      n.valid = 1'b0;
    end else begin
      n.valid = 1'b1;
      n.data  = data[w*W +: W];
      n.chan  = w;
      if (mode) n.ptr = (w + 1) % nch;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma <= '{1'b0, '0, 0, 0, 1'b0};
      mb <= '{1'b0, '0, 0, 0, 1'b0};
    end else begin
      ma <= model_edge(ma, 4, a_mode, int'(a_sel), 16'(a_valid), DW'(a_data), a_out_ready);
      mb <= model_edge(mb, 3, b_mode, int'(b_sel), 16'(b_valid), DW'(b_data), b_out_ready);
    end
  end

  // One clock: sample in_ready just after the inputs settle, then the output register after the edge.
  // Packed as {in_ready, out_valid, out_chan, out_data}; called on a falling edge with inputs set.
  task automatic step(output logic [38:0] oa, output logic [38:0] ea,
                      output logic [37:0] ob, output logic [37:0] eb);
    logic [3:0] ra, rae;
    logic [2:0] rb, rbe;
    #1;
    ra  = a_ready;
    rae = 4'(exp_ready(ma, 4, a_mode, int'(a_sel), 16'(a_valid), a_out_ready));
    rb  = b_ready;
    rbe = 3'(exp_ready(mb, 3, b_mode, int'(b_sel), 16'(b_valid), b_out_ready));
    @(posedge clk);
    @(negedge clk);
    oa = {ra, a_out_valid, a_out_chan, a_out_data};
    ea = {rae, ma.valid, 2'(ma.chan), ma.data};
    ob = {rb, b_out_valid, b_out_chan, b_out_data};
    eb = {rbe, mb.valid, 2'(mb.chan), mb.data};
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [38:0] oa, ea;
    logic [37:0] ob, eb;
    logic [W-1:0] d0;
    a_mode = 1'b1; a_valid = 4'hF; a_out_ready = 1'b1;
    a_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < 4; i++) begin
      step(oa, ea, ob, eb);
      n_cmp++;
      if (oa !== ea) begin n_bad++; $display("FAIL reset_prestream[%0d]: got %h expected %h", i, oa, ea); end
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_ready, a_out_valid, a_out_chan, a_out_data} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_async: got %h expected 0", {a_ready, a_out_valid, a_out_chan, a_out_data});
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    d0 = a_data[W-1:0];
    step(oa, ea, ob, eb);
    n_cmp++;
    if (oa !== {4'b0000, 1'b0, 2'd0, 32'd0}) begin n_bad++; $display("FAIL reset_first_edge: got %h expected %h", oa, {4'b0000, 1'b0, 2'd0, 32'd0}); end
    step(oa, ea, ob, eb);
    n_cmp++;
    if (oa !== {4'b0001, 1'b1, 2'd0, d0}) begin n_bad++; $display("FAIL reset_first_out: got %h expected %h", oa, {4'b0001, 1'b1, 2'd0, d0}); end
  endtask

  task automatic test_fixed();
    logic [38:0] oa, ea;
    logic [37:0] ob, eb;
    a_mode = 1'b0; a_sel = 2'd2; a_valid = 4'hF; a_out_ready = 1'b1;
    a_data = {$urandom(), 32'hDEADBEEF, $urandom(), $urandom()};
    step(oa, ea, ob, eb);
    n_cmp++;
    if (oa !== {4'b0100, 1'b1, 2'd2, 32'hDEADBEEF}) begin n_bad++; $display("FAIL fixed_sel2: got %h expected %h", oa, {4'b0100, 1'b1, 2'd2, 32'hDEADBEEF}); end
    a_sel = 2'd3; a_valid = 4'b0111;
    a_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    step(oa, ea, ob, eb);
    n_cmp++;
    if (oa !== {4'b0000, 1'b0, 2'd2, 32'hDEADBEEF}) begin n_bad++; $display("FAIL fixed_sel3_idle: got %h expected %h", oa, {4'b0000, 1'b0, 2'd2, 32'hDEADBEEF}); end
  endtask

  task automatic test_rr_fair();
    logic [38:0] oa, ea;
    logic [37:0] ob, eb;
    logic [W-1:0] d;
    do_reset();
    a_mode = 1'b1; a_valid = 4'hF; a_out_ready = 1'b1;
    step(oa, ea, ob, eb);
    for (int i = 0; i < 8; i++) begin
      a_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      d = a_data[(i % 4)*W +: W];
      step(oa, ea, ob, eb);
      n_cmp++;
      if (oa !== {4'(1 << (i % 4)), 1'b1, 2'(i % 4), d}) begin
        n_bad++;
        $display("FAIL rr_fair[%0d]: got %h expected %h", i, oa, {4'(1 << (i % 4)), 1'b1, 2'(i % 4), d});
      end
    end
  endtask

  task automatic test_sparse();
    logic [38:0] oa, ea;
    logic [37:0] ob, eb;
    logic [W-1:0] d;
    int c;
    do_reset();
    a_mode = 1'b1; a_valid = 4'b1010; a_out_ready = 1'b1;
    step(oa, ea, ob, eb);
    d = '0;
    for (int i = 0; i < 4; i++) begin
      c = (i % 2 == 0) ? 1 : 3;
      a_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      d = a_data[c*W +: W];
      step(oa, ea, ob, eb);
      n_cmp++;
      if (oa !== {4'(1 << c), 1'b1, 2'(c), d}) begin n_bad++; $display("FAIL sparse[%0d]: got %h expected %h", i, oa, {4'(1 << c), 1'b1, 2'(c), d}); end
    end
    a_valid = 4'b0000;
    a_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    step(oa, ea, ob, eb);
    n_cmp++;
    if (oa !== {4'b0000, 1'b0, 2'd3, d}) begin n_bad++; $display("FAIL sparse_drain: got %h expected %h", oa, {4'b0000, 1'b0, 2'd3, d}); end
  endtask

  task automatic test_back_pressure();
    logic [38:0] oa, ea;
    logic [37:0] ob, eb;
    logic [W-1:0] d1, d2;
    do_reset();
    a_mode = 1'b1; a_valid = 4'b0010; a_out_ready = 1'b1;
    step(oa, ea, ob, eb);
    a_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    d1 = a_data[W +: W];
    step(oa, ea, ob, eb);
    n_cmp++;
    if (oa !== {4'b0010, 1'b1, 2'd1, d1}) begin n_bad++; $display("FAIL bp_load: got %h expected %h", oa, {4'b0010, 1'b1, 2'd1, d1}); end
    a_out_ready = 1'b0; a_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      a_mode = 1'($urandom());
      a_sel  = 2'($urandom());
      a_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(oa, ea, ob, eb);
      n_cmp++;
      if (oa !== {4'b0000, 1'b1, 2'd1, d1}) begin n_bad++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, oa, {4'b0000, 1'b1, 2'd1, d1}); end
    end
    a_out_ready = 1'b1; a_mode = 1'b1;
    a_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    d2 = a_data[2*W +: W];
    step(oa, ea, ob, eb);
    n_cmp++;
    if (oa !== {4'b0100, 1'b1, 2'd2, d2}) begin n_bad++; $display("FAIL bp_release: got %h expected %h", oa, {4'b0100, 1'b1, 2'd2, d2}); end
  endtask

  task automatic test_non_pow2();
    logic [38:0] oa, ea;
    logic [37:0] ob, eb;
    logic [W-1:0] d;
    do_reset();
    b_mode = 1'b1; b_valid = 3'b111; b_out_ready = 1'b1;
    step(oa, ea, ob, eb);
    d = '0;
    for (int i = 0; i < 4; i++) begin
      b_data = {$urandom(), $urandom(), $urandom()};
      d = b_data[(i % 3)*W +: W];
      step(oa, ea, ob, eb);
      n_cmp++;
      if (ob !== {3'(1 << (i % 3)), 1'b1, 2'(i % 3), d}) begin
        n_bad++;
        $display("FAIL npot_rr[%0d]: got %h expected %h", i, ob, {3'(1 << (i % 3)), 1'b1, 2'(i % 3), d});
      end
    end
    b_mode = 1'b0; b_sel = 2'd3;
    b_data = {$urandom(), $urandom(), $urandom()};
    step(oa, ea, ob, eb);
    n_cmp++;
    if (ob !== {3'b000, 1'b0, 2'd0, d}) begin n_bad++; $display("FAIL npot_sel3: got %h expected %h", ob, {3'b000, 1'b0, 2'd0, d}); end
  endtask

  task automatic test_random();
    logic [38:0] oa, ea;
    logic [37:0] ob, eb;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      if ($urandom_range(7) == 0) a_mode = ~a_mode;
      if ($urandom_range(7) == 0) b_mode = ~b_mode;
      a_sel = 2'($urandom()); b_sel = 2'($urandom());
      a_valid = 4'($urandom()); b_valid = 3'($urandom());
      a_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_data = {$urandom(), $urandom(), $urandom()};
      a_out_ready = ($urandom_range(3) != 0);
      b_out_ready = ($urandom_range(3) != 0);
      step(oa, ea, ob, eb);
      n_cmp++;
      if (oa !== ea) begin n_bad++; $display("FAIL random_a[%0d]: got %h expected %h", i, oa, ea); end
      n_cmp++;
      if (ob !== eb) begin n_bad++; $display("FAIL random_b[%0d]: got %h expected %h", i, ob, eb); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1;
    a_data = '0; a_valid = '0; a_mode = 1'b0; a_sel = '0; a_out_ready = 1'b0;
    b_data = '0; b_valid = '0; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_fixed();
    test_rr_fair();
    test_sparse();
    test_back_pressure();
    test_non_pow2();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
